// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage of a five-stage MIPS pipeline. Owns the program
// counter, issues read requests to the instruction cache and feeds the IF/ID
// pipeline register. Handles hazard stalls, downstream branch/jump redirects
// (including ones that land while a cache access is still outstanding) and
// the terminal halt.
//
// Ports
//   CLK                in   system clock, rising-edge active
//   RST                in   synchronous active-high reset
//   ihit               in   imemload is valid for the current imemaddr
//   imemload[31:0]     in   instruction word from the cache
//   imemREN            out  instruction read request
//   imemaddr[31:0]     out  instruction address (always the PC register)
//   stall              in   hazard unit: hold PC and IF/ID contents
//   redirect           in   taken branch/jump resolved downstream
//   redirect_pc[31:0]  in   redirect target (bits [1:0] ignored)
//   halt               in   halt has reached MEM; stop fetching for good
//   IF_instruction_in  out  word to IF/ID; zero (nop bubble) unless accepted
//   IF_pc_add4_in      out  PC + 4 of the current fetch address
//   if_wen             out  IF/ID register write enable
//   fetch_count[31:0]  out  number of accepted instructions (wraps)
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] IF_instruction_in,
    output logic [31:0] IF_pc_add4_in,
    output logic        if_wen,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        ST_FETCH  = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    // Word-align the reset vector so a misconfigured parameter cannot
    // produce an unaligned fetch address.
    localparam logic [31:0] PC_RESET = {PC_INIT[31:2], 2'b00};

    // Architectural state
    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_pend;
    logic [31:0] r_pend_pc;
    logic [31:0] r_fetch_count;

    // Next-state values
    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_pend_nxt;
    logic [31:0] w_pend_pc_nxt;
    logic [31:0] w_fetch_count_nxt;

    // Decoded conditions
    logic        w_fetching;
    logic        w_accept;
    logic [31:0] w_redirect_tgt;
    logic [31:0] w_pc_plus4;
    logic        w_unused_rpc_lsbs;

    // -----------------------------------------------------------------------
    // Combinational outputs
    // -----------------------------------------------------------------------
    assign w_fetching     = (r_state == ST_FETCH);
    assign w_redirect_tgt = {redirect_pc[31:2], 2'b00};
    assign w_pc_plus4     = r_pc + 32'd4;

    // The low target bits are architecturally meaningless for word fetches.
    assign w_unused_rpc_lsbs = ^redirect_pc[1:0];

    // A word is only taken when nothing downstream wants the slot for a
    // bubble: a redirect this cycle or one still waiting for its cache
    // access to retire both discard the returned word.
    assign w_accept = w_fetching & ihit & ~stall & ~redirect & ~r_pend;

    assign imemaddr          = r_pc;
    assign imemREN           = w_fetching;
    assign IF_instruction_in = w_accept ? imemload : 32'h0;
    assign IF_pc_add4_in     = w_pc_plus4;
    // A redirect overrides a stall so that the flush bubble reaches IF/ID.
    assign if_wen            = w_fetching & (~stall | redirect);
    assign fetch_count       = r_fetch_count;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every value written here gets a default first so no path can
        // leave it unassigned and infer a latch.
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_pend_nxt        = r_pend;
        w_pend_pc_nxt     = r_pend_pc;
        w_fetch_count_nxt = r_fetch_count;

        unique case (r_state)
            ST_FETCH: begin
                if (halt) begin
                    // Halt wins over everything, including a redirect.
                    w_state_nxt = ST_HALTED;
                    w_pend_nxt  = 1'b0;
                end else if (redirect && ihit) begin
                    // Cache access just completed: retarget immediately.
                    w_pc_nxt   = w_redirect_tgt;
                    w_pend_nxt = 1'b0;
                end else if (redirect) begin
                    // Access still outstanding: keep the address stable for
                    // the cache and remember where to go once it returns.
                    // A newer redirect simply overwrites the older target.
                    w_pend_nxt    = 1'b1;
                    w_pend_pc_nxt = w_redirect_tgt;
                end else if (r_pend && ihit) begin
                    // The stale access has retired; its word was a bubble.
                    w_pc_nxt   = r_pend_pc;
                    w_pend_nxt = 1'b0;
                end else if (w_accept) begin
                    w_pc_nxt          = w_pc_plus4;
                    w_fetch_count_nxt = r_fetch_count + 32'd1;
                end
                // Otherwise a miss or a plain stall holds everything; a word
                // returned under stall is dropped and fetched again later.
            end

            ST_HALTED: begin
                // Absorbing until reset; all inputs are ignored.
            end

            default: begin
                w_state_nxt = ST_HALTED;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (RST) begin
            r_state       <= ST_FETCH;
            r_pc          <= PC_RESET;
            r_pend        <= 1'b0;
            r_pend_pc     <= 32'h0;
            r_fetch_count <= 32'h0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_pend        <= w_pend_nxt;
            r_pend_pc     <= w_pend_pc_nxt;
            r_fetch_count <= w_fetch_count_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. A behavioural instruction memory answers
// every address with a recognisable word; words the bench expects IF/ID to
// receive are queued when the stimulus is driven and popped when the DUT
// presents them. A second instance with a top-of-memory reset vector covers
// PC wrap-around.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic        CLK;
    logic        RST;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] IF_instruction_in;
    logic [31:0] IF_pc_add4_in;
    logic        if_wen;
    logic [31:0] fetch_count;

    // Second instance (wrap-around)
    logic        ihit_w;
    logic [31:0] imemload_w;
    logic        ren_w_unused;
    logic [31:0] addr_w;
    logic [31:0] instr_w;
    logic [31:0] add4_w;
    logic        wen_w_unused;
    logic [31:0] count_w;

    int          n_checks;
    int          n_errors;
    int          exp_count;
    logic [31:0] sb[$];

    // Instruction memory contents: distinct, non-zero for every address used.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    assign imemload   = instr_of(imemaddr);
    assign imemload_w = instr_of(addr_w);

    fetch_unit #(.PC_INIT(32'h0000_0000)) u_dut (
        .CLK               (CLK),
        .RST               (RST),
        .ihit              (ihit),
        .imemload          (imemload),
        .imemREN           (imemREN),
        .imemaddr          (imemaddr),
        .stall             (stall),
        .redirect          (redirect),
        .redirect_pc       (redirect_pc),
        .halt              (halt),
        .IF_instruction_in (IF_instruction_in),
        .IF_pc_add4_in     (IF_pc_add4_in),
        .if_wen            (if_wen),
        .fetch_count       (fetch_count)
    );

    fetch_unit #(.PC_INIT(32'hFFFF_FFFC)) u_dut_wrap (
        .CLK               (CLK),
        .RST               (RST),
        .ihit              (ihit_w),
        .imemload          (imemload_w),
        .imemREN           (ren_w_unused),
        .imemaddr          (addr_w),
        .stall             (1'b0),
        .redirect          (1'b0),
        .redirect_pc       (32'h0),
        .halt              (1'b0),
        .IF_instruction_in (instr_w),
        .IF_pc_add4_in     (add4_w),
        .if_wen            (wen_w_unused),
        .fetch_count       (count_w)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One fetch cycle: drive inputs just after the rising edge, check at the
    // falling edge, then advance to just after the next rising edge.
    task automatic step(input logic        i_hit,
                        input logic        i_stall,
                        input logic        i_redir,
                        input logic [31:0] i_rpc,
                        input logic        i_halt,
                        input logic [31:0] exp_addr,
                        input logic        exp_ren,
                        input logic        exp_wen,
                        input logic        exp_acc);
        ihit        = i_hit;
        stall       = i_stall;
        redirect    = i_redir;
        redirect_pc = i_rpc;
        halt        = i_halt;
        if (exp_acc) sb.push_back(instr_of(exp_addr));
        @(negedge CLK);
        check("imemaddr",    imemaddr,         exp_addr);
        check("pc_add4",     IF_pc_add4_in,    exp_addr + 32'd4);
        check("imemREN",     {31'b0, imemREN}, {31'b0, exp_ren});
        check("if_wen",      {31'b0, if_wen},  {31'b0, exp_wen});
        check("fetch_count", fetch_count,      exp_count);
        if (!exp_acc) check("bubble", IF_instruction_in, 32'h0);
        if (if_wen && IF_instruction_in != 32'h0) begin
            if (sb.size() == 0) check("unexpected_word", IF_instruction_in, 32'h0);
            else                check("sb_word", IF_instruction_in, sb.pop_front());
        end
        check("sb_drained", sb.size(), 32'd0);
        if (exp_acc) exp_count++;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        exp_count   = 0;
        RST         = 1'b1;
        ihit        = 1'b0;
        ihit_w      = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        halt        = 1'b0;

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_imemaddr", imemaddr,          32'h0);
        check("rst_imemREN",  {31'b0, imemREN},  32'd1);
        check("rst_if_wen",   {31'b0, if_wen},   32'd1);
        check("rst_instr",    IF_instruction_in, 32'h0);
        check("rst_count",    fetch_count,       32'h0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Straight-line fetch: 0, 4, 8, 12
        step(1, 0, 0, 32'h0, 0, 32'h0, 1, 1, 1);
        step(1, 0, 0, 32'h0, 0, 32'h4, 1, 1, 1);
        step(1, 0, 0, 32'h0, 0, 32'h8, 1, 1, 1);
        step(1, 0, 0, 32'h0, 0, 32'hC, 1, 1, 1);

        // Wrap-around on the second instance while the first idles
        ihit   = 1'b0;
        ihit_w = 1'b1;
        @(negedge CLK);
        check("wrap_addr",  addr_w,  32'hFFFF_FFFC);
        check("wrap_add4",  add4_w,  32'h0);
        check("wrap_instr", instr_w, instr_of(32'hFFFF_FFFC));
        @(posedge CLK);
        #1;
        ihit_w = 1'b0;
        @(negedge CLK);
        check("wrap_next_addr", addr_w,  32'h0);
        check("wrap_count",     count_w, 32'd1);
        @(posedge CLK);
        #1;

        // Redirect on hit back to 8 (also checks fetch_count == 4)
        step(1, 0, 1, 32'h8, 0, 32'h10, 1, 1, 0);

        // Stall for three cycles at pc = 8, then release
        step(1, 1, 0, 32'h0, 0, 32'h8, 1, 0, 0);
        step(1, 1, 0, 32'h0, 0, 32'h8, 1, 0, 0);
        step(1, 1, 0, 32'h0, 0, 32'h8, 1, 0, 0);
        step(1, 0, 0, 32'h0, 0, 32'h8, 1, 1, 1);

        // Redirect on hit with stall high: bubble written, target aligned
        step(1, 1, 1, 32'h43, 0, 32'hC, 1, 1, 0);
        step(1, 0, 0, 32'h0,  0, 32'h40, 1, 1, 1);

        // Redirect during miss, overwritten by a second redirect
        step(0, 0, 1, 32'h100, 0, 32'h44, 1, 1, 0);
        step(0, 0, 0, 32'h0,   0, 32'h44, 1, 1, 0);
        step(0, 0, 1, 32'h200, 0, 32'h44, 1, 1, 0);
        repeat (4) step(0, 0, 0, 32'h0, 0, 32'h44, 1, 1, 0);
        step(1, 0, 0, 32'h0, 0, 32'h44,  1, 1, 0);
        step(1, 0, 0, 32'h0, 0, 32'h200, 1, 1, 1);

        // Halt together with a redirect, then inputs are ignored
        step(1, 0, 1, 32'h300, 1, 32'h204, 1, 1, 0);
        step(1, 0, 1, 32'h500, 0, 32'h204, 0, 0, 0);
        step(1, 1, 0, 32'h0,   0, 32'h204, 0, 0, 0);
        step(1, 0, 0, 32'h0,   0, 32'h204, 0, 0, 0);

        // One-cycle reset out of HALTED overrides active inputs
        RST         = 1'b1;
        ihit        = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h700;
        halt        = 1'b1;
        @(posedge CLK);
        #1;
        RST       = 1'b0;
        exp_count = 0;
        step(1, 0, 0, 32'h0, 0, 32'h0, 1, 1, 1);
        step(0, 0, 0, 32'h0, 0, 32'h4, 1, 1, 0);

        check("sb_empty_end", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage MIPS pipeline. Owns the program counter and issues requests to the instruction side of the cache. Feeds the IF/ID pipeline register (`IF_instruction_in`, `IF_pc_add4_in`) and its write enable. Handles three conditions:
- hazard-unit stalls;
- branch/jump redirects resolved downstream, including redirects that arrive while an instruction-memory access is outstanding;
- the terminal halt.

## Interface
- `PC_INIT`, default `32'h0000_0000`: PC value loaded on reset; bits [1:0] must be 0.
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `ihit`  in  1  instruction cache: `imemload` valid for the current `imemaddr` this cycle.
- `imemload`  in  32  instruction word from the cache.
- `imemREN`  out  1  instruction read request.
- `imemaddr`  out  32  instruction address; always equals the PC register.
- `stall`  in  1  hazard unit: hold PC and IF/ID contents.
- `redirect`  in  1  taken branch/jump resolved downstream; flush the in-flight fetch.
- `redirect_pc`  in  32  redirect target; bits [1:0] are ignored and treated as 0.
- `halt`  in  1  halt instruction has reached MEM; stop fetching.
- `IF_instruction_in`  out  32  word to the IF/ID register; `32'h0` (nop bubble) unless accepted.
- `IF_pc_add4_in`  out  32  PC+4 of the current fetch address, modulo 2^32.
- `if_wen`  out  1  IF/ID register write enable.
- `fetch_count`  out  32  number of accepted instructions; wraps modulo 2^32.

## Operation
- **State:** `pc[31:0]`, `pend` (redirect pending), `pend_pc[31:0]`, FSM {FETCH, HALTED}, and `fetch_count`.
- **Reset values:**
  - `pc = PC_INIT`, `pend = 0`, `pend_pc = 0`, state = FETCH, `fetch_count = 0`.
  - Resulting outputs: `imemREN = 1`, `imemaddr = PC_INIT`, `IF_instruction_in = 0`, `if_wen = 1`.
- **Combinational outputs:**
  - `imemaddr = pc`.
  - `imemREN = (state == FETCH)`.
  - `accept = imemREN & ihit & ~stall & ~redirect & ~pend`.
  - `IF_instruction_in = accept ? imemload : 0`.
  - `IF_pc_add4_in = pc + 4`.
  - `if_wen = (state == FETCH) & (~stall | redirect)`. A redirect overrides a stall so the flush bubble is written.
- **Next-state priority in FETCH (first match wins):**
  1. `halt` -> HALTED; clear `pend`; PC holds.
  2. `redirect & ihit` -> `pc = {redirect_pc[31:2], 2'b00}`; `pend = 0`. The returned word is discarded.
  3. `redirect & ~ihit` -> `pend = 1`; `pend_pc = {redirect_pc[31:2], 2'b00}`. PC holds, so the address stays stable while the cache access is outstanding. If `pend` is already set, the newer target overwrites it.
  4. `pend & ihit` -> `pc = pend_pc`; `pend = 0`. The word for the stale address is discarded as a bubble.
  5. `accept` -> `pc = pc + 4` (wraps at `32'hFFFF_FFFC` to 0); `fetch_count++`.
  6. Otherwise (`~ihit`, or `stall` without redirect) -> hold everything. A word returned during a stall is dropped and refetched.
- **HALTED:**
  - Absorbing until `RST`.
  - `imemREN = 0`, `if_wen = 0`, `IF_instruction_in = 0`.
  - `redirect`, `stall`, and `ihit` are ignored; PC and `fetch_count` are frozen.
- **Reset mid-operation:** `RST` overrides every input in the same edge, including a pending redirect and HALTED.

## Timing
- Fetch latency: an instruction is presented to IF/ID in the same cycle as `ihit`. The next address appears on `imemaddr` one cycle later.
- Redirect with `ihit` in cycle N: `imemaddr = target` in N+1.
- Redirect in cycle N with `ihit` low until cycle M: `imemaddr` is unchanged through M, and `imemaddr = target` in M+1. Cycles N..M produce bubbles.
- Stall: `imemaddr` and `if_wen = 0` hold for exactly as many cycles as `stall` is high. The first accept can occur in the first cycle `stall` is low.
- Halt asserted in cycle N: `imemREN = 0` from N+1 onward. A simultaneous `redirect` is ignored.
- `fetch_count` increments on the edge ending each accept cycle, so it is visible the following cycle.

## Test plan
- **Straight-line fetch:** after reset, `ihit = 1` continuously with `stall`, `redirect`, `halt` low, for 4 cycles -> `imemaddr` = 0, 4, 8, 12. `IF_pc_add4_in` = 4, 8, 12, 16. `fetch_count` = 4.
- **Stall:** `stall` high for 3 cycles at `pc = 8` with `ihit = 1` -> `imemaddr` stays 8, `if_wen = 0`, `fetch_count` is unchanged. The cycle after release: word at 8 is accepted and `pc` -> 12.
- **Redirect on hit:** `redirect = 1`, `redirect_pc = 32'h0000_0043`, `ihit = 1`, `stall = 1` -> `IF_instruction_in = 0` and `if_wen = 1` that cycle. Next cycle `imemaddr = 32'h40`.
- **Redirect during miss:** `redirect` to `0x100` while `ihit = 0`, then a second redirect to `0x200` before `ihit`, then `ihit` 5 cycles later -> `imemaddr` stays at the old PC until `ihit`, then `0x200`. Exactly 0 instructions are accepted in the interval.
- **Wrap:** `PC_INIT = 32'hFFFF_FFFC`, one accept -> `IF_pc_add4_in = 0`, next `imemaddr = 0`.
- **Halt and reset:** `halt` together with `redirect` in cycle N -> from N+1, `imemREN = 0` and `imemaddr` frozen, ignoring later `ihit`/`redirect`. `RST` for one cycle -> `imemaddr = PC_INIT`, `imemREN = 1`, `fetch_count = 0`.
